display_scan: RTL and testbench
===============================

DISPLAY_SCAN -- requirements
Module: display_scan

Interface
REQ-001 Parameter PRESCALE, default 50000, clocks per digit slot; SHALL be >= 2.
REQ-002 Parameter DEAD, default 2, blanking clocks at the start of each slot; SHALL be < PRESCALE.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 value_in  input  16  four BCD nibbles; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
REQ-006 load  input  1  one-cycle request to capture value_in.
REQ-007 blank_lz  input  1  enables leading-zero blanking.
REQ-008 digit_code  output  4  nibble for the downstream 7-segment transcoder; 4'hF means blank.
REQ-009 nanode  output  4  active-low one-hot digit enable, bit i selects digit i.
REQ-010 upd_done  output  1  one-cycle pulse when a captured value becomes displayed.

Function
REQ-011 Prescaler cnt SHALL count 0..PRESCALE-1 and wrap to 0; at wrap, digit index idx SHALL advance 0->1->2->3->0.
REQ-012 A frame SHALL be idx 0..3; the frame boundary SHALL be the cycle with idx==3 and cnt==PRESCALE-1.
REQ-013 load==1 SHALL write value_in into pend_q and set pending; a later load before commit SHALL overwrite it (last wins).
REQ-014 At a frame boundary with pending set, value_q SHALL take pend_q and pending SHALL clear; value_q SHALL change at no other time.
REQ-015 A load on a frame-boundary cycle SHALL NOT be committed in that cycle; the previous pend_q SHALL commit, and the new data SHALL stay pending for the next boundary.
REQ-016 upd_done SHALL be registered and high exactly the cycle after a commit; otherwise 0.
REQ-017 nanode and digit_code SHALL be registered, reflecting cnt/idx/value_q of the previous cycle (1-cycle latency).
REQ-018 When cnt < DEAD, nanode SHALL be 4'b1111; otherwise nanode SHALL be ~(4'b0001 << idx).
REQ-019 digit_code SHALL be value_q nibble idx, passed unchanged even if >9 (the transcoder blanks it).
REQ-020 With blank_lz=1, digit i (i=1..3) SHALL be driven 4'hF when nibble i and all higher nibbles of value_q are zero; digit 0 SHALL never be blanked.
REQ-021 blank_lz SHALL be sampled each cycle, with no capture or frame alignment.
REQ-022 Only one nanode bit SHALL ever be low at once.

Reset
REQ-023 With rst=1, the following SHALL be cleared on the next edge: cnt=0, idx=0, value_q=0, pend_q=0, pending=0, nanode=4'b1111, digit_code=4'h0, upd_done=0.
REQ-024 Reset SHALL override load in the same cycle; pending data SHALL be discarded on reset mid-frame.
REQ-025 The first cycle after rst deasserts SHALL have cnt=0, idx=0.

Verification (PRESCALE=4, DEAD=1; cycle 0 = first cycle after rst low)
REQ-026 Hold rst=1 for 3 cycles with load=1, value_in=16'h9999 -> nanode=1111, digit_code=0, upd_done=0 throughout; value_q stays 0.
REQ-027 Load 16'h1234 at cycle 1 -> upd_done high only at cycle 16; cycles 18..19 show nanode=1110, digit_code=4; cycles 22..23 show nanode=1101, digit_code=3.
REQ-028 Load 16'h0050 with blank_lz=1 -> per frame, digit codes d3=F, d2=F, d1=5, d0=0; with value 16'h0000, d0=0 and d1..d3=F; with blank_lz=0, 0,0,5,0.
REQ-029 Load 16'h1111 at cycle 2, then 16'h2222 at cycle 5 -> a single upd_done at cycle 16; displayed value is 2222; 1111 is never shown.
REQ-030 Pending 16'h1111, then load 16'h2222 on boundary cycle 15 -> 1111 commits (upd_done at 16); 2222 commits at cycle 31 (upd_done at 32).
REQ-031 Assert rst at cycle 9 (idx=2), with pending set -> at cycle 10 all REQ-023 values hold; after release, no upd_done without a new load.

Source files
------------

// File: rtl/display_scan.sv
// display_scan: four-digit multiplexed BCD display scanner.
// Values commit only on frame boundaries so a digit never tears mid-frame.
module display_scan #(
  parameter int PRESCALE = 50000,
  parameter int DEAD     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value_in,
  input  logic        load,
  input  logic        blank_lz,
  output logic [3:0]  digit_code,
  output logic [3:0]  nanode,
  output logic        upd_done
);

  localparam int CW = $clog2(PRESCALE);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   value_q, value_d;
  logic [15:0]   pend_q, pend_d;
  logic          pending_q, pending_d;
  logic [3:0]    nanode_q, nanode_d;
  logic [3:0]    digit_q, digit_d;
  logic          upd_q, upd_d;

  logic          wrap;
  logic          boundary;
  logic [3:0]    nib;
  logic          lz;

  // Scan timing, pending/commit bookkeeping and registered outputs.
  always_comb begin
    wrap      = (cnt_q == CW'(PRESCALE - 1));
    boundary  = wrap && (idx_q == 2'd3);
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    value_d   = value_q;
    pend_d    = pend_q;
    pending_d = pending_q;
    nanode_d  = 4'hF;
    digit_d   = 4'h0;
    upd_d     = 1'b0;
    nib       = 4'h0;
    lz        = 1'b0;

    unique case (idx_q)
      2'd0: nib = value_q[3:0];
      2'd1: nib = value_q[7:4];
      2'd2: nib = value_q[11:8];
      2'd3: nib = value_q[15:12];
      default: nib = 4'h0;
    endcase

    unique case (idx_q)
      2'd0: lz = 1'b0;
      2'd1: lz = (value_q[15:4] == 12'h000);
      2'd2: lz = (value_q[15:8] == 8'h00);
      2'd3: lz = (value_q[15:12] == 4'h0);
      default: lz = 1'b0;
    endcase

    if (rst) begin
      cnt_d     = '0;
      idx_d     = 2'd0;
      value_d   = 16'h0000;
      pend_d    = 16'h0000;
      pending_d = 1'b0;
      nanode_d  = 4'hF;
      digit_d   = 4'h0;
      upd_d     = 1'b0;
    end else begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
      idx_d = wrap ? idx_q + 2'd1 : idx_q;

      if (load) begin
        pend_d    = value_in;
        pending_d = 1'b1;
      end

      // A boundary load stays pending; the older data commits now.
      if (boundary && pending_q) begin
        value_d   = pend_q;
        pending_d = load;
        upd_d     = 1'b1;
      end

      if (cnt_q < CW'(DEAD))
        nanode_d = 4'hF;
      else
        nanode_d = ~(4'b0001 << idx_q);

      digit_d = (blank_lz && lz) ? 4'hF : nib;
    end
  end

  // State register; reset is folded into the next-state logic.
  always_ff @(posedge clk) begin
    cnt_q     <= cnt_d;
    idx_q     <= idx_d;
    value_q   <= value_d;
    pend_q    <= pend_d;
    pending_q <= pending_d;
    nanode_q  <= nanode_d;
    digit_q   <= digit_d;
    upd_q     <= upd_d;
  end

  assign digit_code = digit_q;
  assign nanode     = nanode_q;
  assign upd_done   = upd_q;

endmodule

// File: tb/tb_display_scan.sv
// tb_display_scan: directed checks of display_scan
// with PRESCALE=4, DEAD=1 (16-cycle frames).
module tb_display_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value_in = 16'h0000;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [3:0]  digit_code;
  logic [3:0]  nanode;
  logic        upd_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  display_scan #(.PRESCALE(4), .DEAD(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .value_in   (value_in),
    .load       (load),
    .blank_lz   (blank_lz),
    .digit_code (digit_code),
    .nanode     (nanode),
    .upd_done   (upd_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    load = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    load = 1'b1;
    value_in = 16'h9999;
    blank_lz = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (nanode !== 4'hF || digit_code !== 4'h0 || upd_done !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold i=%0d got an=%b dc=%h ud=%b exp 1111/0/0",
                 i, nanode, digit_code, upd_done);
      end
    end
    load = 1'b0;
    rst = 1'b0;
    cyc = 0;
    while (cyc < 20) begin
      checks++;
      if (upd_done !== 1'b0) begin
        errors++;
        $display("FAIL reset_noupd cyc=%0d got %b exp 0", cyc, upd_done);
      end
      if (nanode !== 4'hF) begin
        checks++;
        if (digit_code !== 4'h0) begin
          errors++;
          $display("FAIL reset_val cyc=%0d got %h exp 0", cyc, digit_code);
        end
      end
      step();
    end
  endtask

  task automatic test_basic();
    do_reset();
    blank_lz = 1'b0;
    step();
    load = 1'b1;
    value_in = 16'h1234;
    step();
    load = 1'b0;
    while (cyc <= 24) begin
      checks++;
      if (upd_done !== (cyc == 16)) begin
        errors++;
        $display("FAIL basic_upd cyc=%0d got %b exp %b",
                 cyc, upd_done, cyc == 16);
      end
      if (cyc == 17 || cyc == 21) begin
        checks++;
        if (nanode !== 4'b1111) begin
          errors++;
          $display("FAIL basic_dead cyc=%0d got %b exp 1111", cyc, nanode);
        end
      end
      if (cyc == 18 || cyc == 19) begin
        checks++;
        if (nanode !== 4'b1110 || digit_code !== 4'h4) begin
          errors++;
          $display("FAIL basic_d0 cyc=%0d got %b/%h exp 1110/4",
                   cyc, nanode, digit_code);
        end
      end
      if (cyc == 22 || cyc == 23) begin
        checks++;
        if (nanode !== 4'b1101 || digit_code !== 4'h3) begin
          errors++;
          $display("FAIL basic_d1 cyc=%0d got %b/%h exp 1101/3",
                   cyc, nanode, digit_code);
        end
      end
      step();
    end
  endtask

  task automatic test_lz();
    logic [3:0] exp_dc;
    logic [3:0] exp_an;
    int f;
    int d;
    do_reset();
    blank_lz = 1'b1;
    step();
    load = 1'b1;
    value_in = 16'h0050;
    step();
    load = 1'b0;
    while (cyc <= 46) begin
      if (cyc == 32) blank_lz = 1'b0;
      if (cyc >= 2 && ((cyc - 2) % 4) == 0) begin
        f = (cyc - 2) / 16;
        d = ((cyc - 2) / 4) % 4;
        exp_an = 4'hF;
        exp_an[d] = 1'b0;
        exp_dc = 4'h0;
        if (f == 0) exp_dc = (d == 0) ? 4'h0 : 4'hF;
        if (f == 1) begin
          case (d)
            0: exp_dc = 4'h0;
            1: exp_dc = 4'h5;
            default: exp_dc = 4'hF;
          endcase
        end
        if (f == 2) exp_dc = (d == 1) ? 4'h5 : 4'h0;
        checks++;
        if (nanode !== exp_an || digit_code !== exp_dc) begin
          errors++;
          $display("FAIL lz cyc=%0d got %b/%h exp %b/%h",
                   cyc, nanode, digit_code, exp_an, exp_dc);
        end
      end
      step();
    end
  endtask

  task automatic test_last_wins();
    do_reset();
    blank_lz = 1'b0;
    while (cyc <= 40) begin
      load = (cyc == 2) || (cyc == 5);
      value_in = (cyc == 2) ? 16'h1111 : 16'h2222;
      checks++;
      if (upd_done !== (cyc == 16)) begin
        errors++;
        $display("FAIL lw_upd cyc=%0d got %b exp %b",
                 cyc, upd_done, cyc == 16);
      end
      if (nanode !== 4'hF) begin
        checks++;
        if (digit_code === 4'h1) begin
          errors++;
          $display("FAIL lw_stale cyc=%0d got 1 exp not 1", cyc);
        end
      end
      if (cyc == 18 || cyc == 22 || cyc == 26 || cyc == 30) begin
        checks++;
        if (digit_code !== 4'h2) begin
          errors++;
          $display("FAIL lw_val cyc=%0d got %h exp 2", cyc, digit_code);
        end
      end
      step();
    end
    load = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    blank_lz = 1'b0;
    while (cyc <= 40) begin
      load = (cyc == 2) || (cyc == 15);
      value_in = (cyc == 2) ? 16'h1111 : 16'h2222;
      checks++;
      if (upd_done !== (cyc == 16 || cyc == 32)) begin
        errors++;
        $display("FAIL b2b_upd cyc=%0d got %b exp %b",
                 cyc, upd_done, cyc == 16 || cyc == 32);
      end
      if (cyc == 18 || cyc == 34) begin
        checks++;
        if (digit_code !== ((cyc == 18) ? 4'h1 : 4'h2)) begin
          errors++;
          $display("FAIL b2b_val cyc=%0d got %h exp %h", cyc,
                   digit_code, (cyc == 18) ? 4'h1 : 4'h2);
        end
      end
      step();
    end
    load = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    blank_lz = 1'b0;
    step();
    load = 1'b1;
    value_in = 16'h1234;
    step();
    load = 1'b0;
    while (cyc < 9) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (nanode !== 4'hF || digit_code !== 4'h0 || upd_done !== 1'b0) begin
      errors++;
      $display("FAIL rmid_clr got %b/%h/%b exp 1111/0/0",
               nanode, digit_code, upd_done);
    end
    cyc = 0;
    while (cyc <= 40) begin
      checks++;
      if (upd_done !== 1'b0) begin
        errors++;
        $display("FAIL rmid_upd cyc=%0d got %b exp 0", cyc, upd_done);
      end
      if (cyc == 2) begin
        checks++;
        if (nanode !== 4'b1110) begin
          errors++;
          $display("FAIL rmid_idx got %b exp 1110", nanode);
        end
      end
      if (nanode !== 4'hF) begin
        checks++;
        if (digit_code !== 4'h0) begin
          errors++;
          $display("FAIL rmid_val cyc=%0d got %h exp 0", cyc, digit_code);
        end
      end
      step();
    end
  endtask

  // Only one anode may ever be driven low.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if ($countones(~nanode) > 1) begin
        errors++;
        $display("FAIL onehot got %b exp at most one low", nanode);
      end
    end
  end

  initial begin
    test_reset();
    test_basic();
    test_lz();
    test_last_wins();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
